// File: rtl/bram_arb_pkg.sv
// Shared constants and request type for the two-client block RAM arbiter.
package bram_arb_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREQ   = 2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The last-granted bit resets to 1 so client 0 wins first contention.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o
);

  logic            last_q, last_d;
  logic [NREQ-1:0] gnt;

  always_comb begin
    gnt = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
    last_d = last_q;
    if (|gnt) last_d = gnt[1];
  end

  assign gnt_o = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-client arbiter for a 256x16 BRAM with independent round-robin read and write ports.
// Define BRAM_ARB_FWD_EN to grant same-address read/write together and forward the write data.
module bram_arbiter #(
  parameter int unsigned ADDR_W = bram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = bram_arb_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_0,
  input  logic              i_req_1,
  input  logic              i_wr_0,
  input  logic              i_wr_1,
  input  logic [ADDR_W-1:0] i_addr_0,
  input  logic [ADDR_W-1:0] i_addr_1,
  input  logic [DATA_W-1:0] i_wdata_0,
  input  logic [DATA_W-1:0] i_wdata_1,
  output logic              o_ack_0,
  output logic              o_ack_1,
  output logic              o_rvalid_0,
  output logic              o_rvalid_1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata
);

  logic [1:0]        ack_q, rpend_q, rvalid_q;
  logic [1:0]        req_v, wr_req, rd_req, wgnt, rgnt;
  logic              wr_en_q, rd_en_q, collide, rd_arb_en;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [DATA_W-1:0] wdata_q, rdata_sel;

  // A client's request is ignored during its own ack cycle.
  assign req_v  = {i_req_1, i_req_0} & ~ack_q;
  assign wr_req = req_v & {i_wr_1, i_wr_0};
  assign rd_req = req_v & ~{i_wr_1, i_wr_0};

  // With two clients, a concurrent write and read always come from different clients.
  assign collide = (i_addr_0 == i_addr_1) & (|wr_req) & (|rd_req);

`ifdef BRAM_ARB_FWD_EN
  assign rd_arb_en = 1'b1;
`else
  assign rd_arb_en = ~collide;
`endif

  rr_arb2 u_wr_arb (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .req_i  (wr_req),
    .en_i   (1'b1),
    .gnt_o  (wgnt)
  );

  rr_arb2 u_rd_arb (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .req_i  (rd_req),
    .en_i   (rd_arb_en),
    .gnt_o  (rgnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q    <= '0;
      wr_en_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rd_en_q  <= 1'b0;
      raddr_q  <= '0;
      rpend_q  <= '0;
      rvalid_q <= '0;
    end else begin
      ack_q   <= wgnt | rgnt;
      wr_en_q <= |wgnt;
      if (|wgnt) begin
        waddr_q <= wgnt[1] ? i_addr_1 : i_addr_0;
        wdata_q <= wgnt[1] ? i_wdata_1 : i_wdata_0;
      end
      rd_en_q <= |rgnt;
      if (|rgnt) begin
        raddr_q <= rgnt[1] ? i_addr_1 : i_addr_0;
      end
      rpend_q  <= rgnt;
      rvalid_q <= rpend_q;
    end
  end

`ifdef BRAM_ARB_FWD_EN
  logic              fwd_pend_q, fwd_q;
  logic [DATA_W-1:0] fwd_data_q;

  // wdata_q still holds the colliding write one edge after the grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fwd_pend_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_pend_q <= collide;
      fwd_q      <= fwd_pend_q;
      if (fwd_pend_q) fwd_data_q <= wdata_q;
    end
  end

  assign rdata_sel = fwd_q ? fwd_data_q : i_rdata;
`else
  assign rdata_sel = i_rdata;
`endif

  always_comb begin
    o_rdata = '0;
    if (|rvalid_q) o_rdata = rdata_sel;
  end

  assign o_ack_0    = ack_q[0];
  assign o_ack_1    = ack_q[1];
  assign o_rvalid_0 = rvalid_q[0];
  assign o_rvalid_1 = rvalid_q[1];
  assign o_wr_en    = wr_en_q;
  assign o_waddr    = waddr_q;
  assign o_wdata    = wdata_q;
  assign o_rd_en    = rd_en_q;
  assign o_raddr    = raddr_q;

endmodule
